// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam int HDR_W      = 16;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        LOAD   = 3'd2,
        FLUSH  = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_byte_packer.sv
// ============================================================================
// Module      : prog_loader_byte_packer
// Description : Shifts bytes MSB-first into a 32-bit word; flags the 4th byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_done
);

    // Only the three older bytes need storage; the newest byte is the live input.
    logic [WORD_W-9:0] r_word;
    logic [BCNT_W-1:0] r_cnt;
    logic [WORD_W-1:0] w_word;

    assign w_word      = {r_word, i_byte};
    assign o_word      = w_word;
    assign o_word_done = i_shift_en && (r_cnt == BCNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift_en) begin
            r_word <= w_word[WORD_W-9:0];
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Boot loader: parses a counted byte stream into instruction
//               memory writes, then releases the processor from reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] c_CAP = 32'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_state_next;
    logic [HDR_W-1:0]  r_count;
    logic [ADDR_W:0]   r_widx;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [WORD_W-1:0] r_imem_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_shift_en;
    logic              w_clear;
    logic [HDR_W-1:0]  w_hdr_full;
    logic [ADDR_W:0]   w_widx_inc;
    logic              w_last_word;
    logic [WORD_W-1:0] w_word;
    logic              w_word_done;

    assign in_ready = !rst && ((r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == LOAD));
    assign w_accept    = in_valid && in_ready;
    assign w_shift_en  = w_accept && (r_state == LOAD);
    assign w_clear     = (r_state != LOAD);
    assign w_hdr_full  = {r_count[HDR_W-1:8], in_data};
    assign w_widx_inc  = r_widx + {{ADDR_W{1'b0}}, 1'b1};
    // The word being completed is the last one when its 1-based index equals the count.
    assign w_last_word = (32'(w_widx_inc) == 32'(r_count));

    prog_loader_byte_packer u_byte_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_shift_en  (w_shift_en),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HDR_HI: begin
                if (w_accept) w_state_next = HDR_LO;
            end
            HDR_LO: begin
                if (w_accept) begin
                    if (w_hdr_full == '0)
                        w_state_next = RUN;
                    else if (32'(w_hdr_full) > c_CAP)
                        w_state_next = ERR;
                    else
                        w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (w_word_done && w_last_word) w_state_next = FLUSH;
            end
            FLUSH:   w_state_next = RUN;
            RUN:     w_state_next = RUN;
            ERR:     w_state_next = ERR;
            default: w_state_next = HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HDR_HI;
            r_count      <= '0;
            r_widx       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_imem_we <= 1'b0;
            if (w_accept && (r_state == HDR_HI)) r_count[HDR_W-1:8] <= in_data;
            if (w_accept && (r_state == HDR_LO)) r_count[7:0]       <= in_data;
            if (w_word_done) begin
                r_imem_we    <= 1'b1;
                r_imem_wdata <= w_word;
                r_imem_addr  <= r_widx[ADDR_W-1:0];
                r_widx       <= w_widx_inc;
            end
            // RUN is reached either via FLUSH or directly from an empty header.
            if ((r_state == FLUSH) || (r_state == RUN)) begin
                r_cpu_rst <= 1'b0;
                r_done    <= 1'b1;
            end
            if (w_state_next == ERR) r_err <= 1'b1;
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

`default_nettype wire
